// File: rtl/mem_responder_if.sv
// Core data-port bus plus output-stream handshake between the core/consumer
// (master) and the memory responder (slave).
interface mem_responder_if;
   logic        mem_read;
   logic        mem_wren;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic [31:0] memwrite_data;
   logic [31:0] memread_data;
   logic        mem_stall;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        fault;
   logic [31:0] fault_addr;

   modport master (
      output mem_read, mem_wren, mem_addr, mem_size, memwrite_data, out_ready,
      input  memread_data, mem_stall, out_valid, out_data, fault, fault_addr
   );

   modport slave (
      input  mem_read, mem_wren, mem_addr, mem_size, memwrite_data, out_ready,
      output memread_data, mem_stall, out_valid, out_data, fault, fault_addr
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: word-organised data RAM with byte/half/word lanes,
// a memory-mapped output FIFO with status register, and a sticky
// misaligned-access fault recorder.
module mem_responder #(
   parameter int unsigned MEM_WORDS = 16,
   parameter int unsigned OUT_DEPTH = 4,
   parameter logic [31:0] OUT_ADDR  = 32'h0800_0000
) (
   input logic             clk,
   input logic             rst_n,
   mem_responder_if.slave  bus
);

   localparam int unsigned AW        = $clog2(MEM_WORDS);
   localparam int unsigned CW        = $clog2(OUT_DEPTH);
   localparam logic [31:0] STAT_ADDR = OUT_ADDR + 32'd4;
   localparam logic [CW:0] DEPTH_C   = (CW+1)'(OUT_DEPTH);

   // Storage
   logic [31:0]   ram_q  [MEM_WORDS];
   logic [31:0]   fifo_q [OUT_DEPTH];

   // State registers and next-state values
   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          valid_q, valid_d;
   logic [31:0]   memread_q, memread_d;
   logic          fault_q, fault_d;
   logic [31:0]   fault_addr_q, fault_addr_d;

   // Decode / datapath signals
   logic          sel_out_s;
   logic          sel_stat_s;
   logic          misalign_s;
   logic          stall_s;
   logic          wr_s;
   logic          rd_s;
   logic          push_s;
   logic          pop_s;
   logic [AW-1:0] widx_s;
   logic [3:0]    be_s;
   logic [31:0]   wdat_s;
   logic [31:0]   rshift_s;
   logic [31:0]   stat_s;

   assign widx_s = bus.mem_addr[AW+1:2];

   // Address decode, alignment check and request qualification
   always_comb begin
      sel_out_s  = (bus.mem_addr == OUT_ADDR);
      sel_stat_s = (bus.mem_addr == STAT_ADDR);
      case (bus.mem_size)
         2'd0:    misalign_s = 1'b0;
         2'd1:    misalign_s = bus.mem_addr[0];
         default: misalign_s = (bus.mem_addr[1:0] != 2'b00);
      endcase
      // Stall looks only at the registered full flag, never at out_ready
      stall_s = bus.mem_wren & sel_out_s & full_q;
      wr_s    = bus.mem_wren & ~misalign_s & ~stall_s;
      rd_s    = bus.mem_read & ~bus.mem_wren & ~misalign_s;
      push_s  = wr_s & sel_out_s;
      pop_s   = valid_q & bus.out_ready;
   end

   // Byte-enable and lane-replicated write data for sub-word stores
   always_comb begin
      case (bus.mem_size)
         2'd0: begin
            be_s   = 4'b0001 << bus.mem_addr[1:0];
            wdat_s = {4{bus.memwrite_data[7:0]}};
         end
         2'd1: begin
            be_s   = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
            wdat_s = {2{bus.memwrite_data[15:0]}};
         end
         default: begin
            be_s   = 4'b1111;
            wdat_s = bus.memwrite_data;
         end
      endcase
   end

   // RAM lane writes; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_s && !sel_out_s && !sel_stat_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               ram_q[widx_s][8*i +: 8] <= wdat_s[8*i +: 8];
            end
         end
      end
   end

   // Status word: pre-update count and flags
   always_comb begin
      stat_s             = 32'd0;
      stat_s[8 +: CW+1]  = count_q;
      stat_s[1]          = full_q;
      stat_s[0]          = ~valid_q;
   end

   // Read data next value: right-align the selected lanes and zero-extend
   always_comb begin
      rshift_s  = ram_q[widx_s] >> {bus.mem_addr[1:0], 3'b000};
      memread_d = memread_q;
      if (rd_s) begin
         if (sel_out_s) begin
            memread_d = 32'd0;
         end else if (sel_stat_s) begin
            memread_d = stat_s;
         end else begin
            case (bus.mem_size)
               2'd0:    memread_d = {24'd0, rshift_s[7:0]};
               2'd1:    memread_d = {16'd0, rshift_s[15:0]};
               default: memread_d = rshift_s;
            endcase
         end
      end else begin
         memread_d = memread_q;
      end
   end

   // FIFO pointer/count next state and sticky fault capture
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + CW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + CW'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (CW+1)'(1);
         2'b01:   count_d = count_q - (CW+1)'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == DEPTH_C);
      valid_d = (count_d != (CW+1)'(0));

      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      if (misalign_s && (bus.mem_read || bus.mem_wren)) begin
         fault_d = 1'b1;
         if (!fault_q) begin
            fault_addr_d = bus.mem_addr;
         end else begin
            fault_addr_d = fault_addr_q;
         end
      end else begin
         fault_d = fault_q;
      end
   end

   // Control/status registers and FIFO storage, cleared by async reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         valid_q      <= 1'b0;
         memread_q    <= 32'd0;
         fault_q      <= 1'b0;
         fault_addr_q <= 32'd0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            fifo_q[i] <= 32'd0;
         end
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         full_q       <= full_d;
         valid_q      <= valid_d;
         memread_q    <= memread_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         if (push_s) begin
            fifo_q[wr_ptr_q] <= bus.memwrite_data;
         end
      end
   end

   assign bus.memread_data = memread_q;
   assign bus.mem_stall    = stall_s;
   assign bus.out_valid    = valid_q;
   assign bus.out_data     = fifo_q[rd_ptr_q];
   assign bus.fault        = fault_q;
   assign bus.fault_addr   = fault_addr_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's data port. It services the core's `mem_read`/`mem_wren` requests against a small word-organised data RAM with byte/half/word lane handling. It decodes a memory-mapped output port into a buffered FIFO drained by a valid/ready consumer, and records misaligned-access faults. It sits between the core and the chip top, replacing the top-level inline memory and output register.

## Interface
- `MEM_WORDS`, 16, data RAM depth in 32-bit words (power of two).
- `OUT_DEPTH`, 4, output FIFO depth in entries (power of two, >= 2).
- `OUT_ADDR`, 32'h0800_0000, byte address of the output data register; `OUT_ADDR+4` is the status register.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_read` in 1: read request this cycle.
- `mem_wren` in 1: write request this cycle.
- `mem_addr` in 32: byte address.
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `memwrite_data` in 32: write data, right-aligned (byte in [7:0], half in [15:0]).
- `memread_data` out 32: registered read data, right-aligned, zero-extended.
- `mem_stall` out 1: combinational; the request is not accepted this cycle and the core must hold it.
- `out_valid` out 1: FIFO head is valid.
- `out_data` out 32: FIFO head word.
- `out_ready` in 1: consumer accepts the head this cycle.
- `fault` out 1: sticky misaligned-access flag.
- `fault_addr` out 32: address of the first faulting access.

## Operation
- **Decode.** `mem_addr == OUT_ADDR` selects OUT. `mem_addr == OUT_ADDR+4` selects STAT. All other addresses select RAM, indexed by word `mem_addr[$clog2(MEM_WORDS)+1:2]` (upper bits alias).
- **Alignment.** Half with `addr[0]=1`, or word with `addr[1:0]!=0`, is misaligned.
  - The access is suppressed: no RAM/FIFO change and `memread_data` holds.
  - `fault` sets. `fault_addr` is captured only if `fault` was 0.
  - Both are cleared only by reset.
- **Simultaneous requests.** If `mem_read` and `mem_wren` are both high, the write is performed and the read is ignored.
- **RAM write.**
  - Byte: `memwrite_data[7:0]` goes to lane `addr[1:0]`.
  - Half: `memwrite_data[15:0]` goes to lanes `addr[1]*2 +: 2`.
  - Word: all four lanes are written.
  - Other lanes are unchanged. RAM contents are not reset.
- **RAM read.** The selected lane(s) are shifted to bit 0 and zero-extended into `memread_data`.
- **OUT write.** Pushes the full `memwrite_data` regardless of size.
  - If the FIFO is full, `mem_stall=1` and nothing is pushed.
  - `mem_stall` depends only on the registered full flag and the decode; there is no path from `out_ready`.
- **OUT read.** Returns 0.
- **STAT read.** Returns {zero padding, count[$clog2(OUT_DEPTH):0] at [15:8], full at [1], empty at [0]}.
- **FIFO.**
  - Pop occurs when `out_valid && out_ready`. `out_data` is the head entry; it is stable while `out_valid && !out_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - When full, a pop in a cycle where a push stalls frees a slot; the held push is accepted the next cycle.
  - Pointers wrap modulo `OUT_DEPTH`. Count saturates nowhere; it ranges 0..OUT_DEPTH.

## Timing
- **Reset values.** `memread_data=0`, `out_valid=0`, `out_data=0` (empty), `fault=0`, `fault_addr=0`, FIFO pointers and count 0, `mem_stall=0`.
- **Asynchronous reset mid-operation.** Immediately empties the FIFO (queued words are lost) and clears the fault. RAM is retained.
- **Read latency.** 1 cycle: data requested in cycle N is on `memread_data` from cycle N+1 and held until the next accepted read.
- **Write latency.** A write in cycle N is visible to a read issued in cycle N+1.
- **OUT push latency.** A push in cycle N gives `out_valid=1` from N+1 if the FIFO was empty. There is no bypass from write to `out_data` in the same cycle.
- **Stall.** `mem_stall` is asserted in the same cycle as the offending request. The request has no effect until a cycle with `mem_stall=0`.
- **Status coherence.** A STAT read reflects count/flags before the current cycle's push/pop.

## Test plan
- Word write 0xDEADBEEF @0x10; byte write 0x5A @0x11; read word @0x10 -> 0xDEAD5AEF. Half read @0x12 -> 0x0000DEAD. Byte read @0x13 -> 0x000000DE, each one cycle after request.
- Push 5 words 1..5 to OUT_ADDR with `out_ready=0`, depth 4 -> 4 accepted. `mem_stall=1` on the fifth and held. STAT read -> count=4, full=1. Raise `out_ready` -> pops 1,2,3,4 in order, fifth accepted one cycle after first pop, then 5 pops.
- Simultaneous push and pop with count=2 for 10 cycles -> count stays 2, `out_data` sequence in push order, no stall.
- Word write @0x6 then half read @0x9 -> both suppressed. `fault=1`, `fault_addr=0x6` (not 0x9), RAM unchanged, `memread_data` holds.
- Assert `rst` low asynchronously between clock edges with FIFO count=3 and fault set -> `out_valid=0`, `fault=0` immediately. A prior RAM word reads back unchanged after release.
- `mem_read` and `mem_wren` high together @0x20 with data 0x12345678 -> write performed, `memread_data` unchanged. Next read @0x20 -> 0x12345678.
